// File: rtl/switch_conditioner.sv
// Per-channel synchroniser and debouncer for raw mechanical switches, producing a clean level,
// press/release pulses and a press-toggled state; fsmState shows which channels are mid-count.
module switch_conditioner #(
  parameter int NUM_SWITCHES    = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                    clock,
  input  logic                    isReset,
  input  logic [NUM_SWITCHES-1:0] switchIn,
  output logic [NUM_SWITCHES-1:0] switchLevel,
  output logic [NUM_SWITCHES-1:0] switchPress,
  output logic [NUM_SWITCHES-1:0] switchRelease,
  output logic [NUM_SWITCHES-1:0] switchToggle,
  output logic                    anyEvent,
  output logic [NUM_SWITCHES-1:0] fsmState
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q, toggle_q;

    // Synchroniser idles at the inactive raw level so an untouched input is quiet after reset.
    always_ff @(posedge clock or posedge isReset) begin
      if (isReset) begin
        sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], switchIn[g]};
      end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
        ST_STABLE: begin
          if (sample != level_q) begin
            state_d = ST_COUNTING;
            cnt_d   = CNT_ONE;
          end
        end
        ST_COUNTING: begin
          if (sample == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Pulses and toggle are registered alongside the level so they line up with its change.
    always_ff @(posedge clock or posedge isReset) begin
      if (isReset) begin
        state_q   <= ST_STABLE;
        cnt_q     <= CNT_ZERO;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= level_d & ~level_q;
        release_q <= ~level_d & level_q;
        toggle_q  <= toggle_q ^ (level_d & ~level_q);
      end
    end

    assign switchLevel[g]   = level_q;
    assign switchPress[g]   = press_q;
    assign switchRelease[g] = release_q;
    assign switchToggle[g]  = toggle_q;
    assign fsmState[g]      = state_q[0];
  end

  assign anyEvent = |(switchPress | switchRelease);

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: an active-high and an active-low instance checked every cycle
// against a run-length reference model, plus directed latency and glitch scenarios.
module tb_switch_conditioner;
  localparam int NSW = 4;
  localparam int DEB = 16;
  localparam int SYN = 2;

  logic           clock = 1'b0;
  logic           isReset;
  logic [NSW-1:0] sw0, sw1;
  logic [NSW-1:0] lvl0, prs0, rel0, tog0, st0;
  logic [NSW-1:0] lvl1, prs1, rel1, tog1, st1;
  logic           any0, any1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: delay line of raw samples and a count of consecutive disagreeing edges.
  bit pipe_m [2][NSW][SYN];
  int run_m  [2][NSW];
  bit lvl_m  [2][NSW];
  bit prs_m  [2][NSW];
  bit rel_m  [2][NSW];
  bit tog_m  [2][NSW];

  switch_conditioner #(.NUM_SWITCHES(NSW), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYN),
                       .ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .isReset(isReset), .switchIn(sw0),
    .switchLevel(lvl0), .switchPress(prs0), .switchRelease(rel0), .switchToggle(tog0),
    .anyEvent(any0), .fsmState(st0)
  );

  switch_conditioner #(.NUM_SWITCHES(NSW), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYN),
                       .ACTIVE_LOW(1'b1)) dut_al (
    .clock(clock), .isReset(isReset), .switchIn(sw1),
    .switchLevel(lvl1), .switchPress(prs1), .switchRelease(rel1), .switchToggle(tog1),
    .anyEvent(any1), .fsmState(st1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int ch = 0; ch < NSW; ch++) begin
        for (int k = 0; k < SYN; k++) pipe_m[u][ch][k] = (u == 1);
        run_m[u][ch] = 0;
        lvl_m[u][ch] = 1'b0;
        prs_m[u][ch] = 1'b0;
        rel_m[u][ch] = 1'b0;
        tog_m[u][ch] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int u, input logic [NSW-1:0] raw);
    bit s;
    for (int ch = 0; ch < NSW; ch++) begin
      s = pipe_m[u][ch][SYN-1] ^ (u == 1);
      for (int k = SYN - 1; k > 0; k--) pipe_m[u][ch][k] = pipe_m[u][ch][k-1];
      pipe_m[u][ch][0] = raw[ch];
      prs_m[u][ch] = 1'b0;
      rel_m[u][ch] = 1'b0;
      if (s != lvl_m[u][ch]) begin
        run_m[u][ch]++;
        if (run_m[u][ch] == DEB) begin
          lvl_m[u][ch] = s;
          run_m[u][ch] = 0;
          if (s) begin
            prs_m[u][ch] = 1'b1;
            tog_m[u][ch] = !tog_m[u][ch];
          end else begin
            rel_m[u][ch] = 1'b1;
          end
        end
      end else begin
        run_m[u][ch] = 0;
      end
    end
  endtask

  always @(posedge clock) begin
    if (isReset) model_reset();
    else begin
      model_step(0, sw0);
      model_step(1, sw1);
    end
  end

  task automatic compare_all();
    logic [NSW-1:0] el, ep, er, et, es, ol, op, orl, ot, os;
    logic oa;
    for (int u = 0; u < 2; u++) begin
      for (int ch = 0; ch < NSW; ch++) begin
        el[ch] = lvl_m[u][ch];
        ep[ch] = prs_m[u][ch];
        er[ch] = rel_m[u][ch];
        et[ch] = tog_m[u][ch];
        es[ch] = (run_m[u][ch] != 0);
      end
      if (u == 0) begin
        ol = lvl0; op = prs0; orl = rel0; ot = tog0; os = st0; oa = any0;
      end else begin
        ol = lvl1; op = prs1; orl = rel1; ot = tog1; os = st1; oa = any1;
      end
      check($sformatf("u%0d_level", u),   32'(ol),  32'(el));
      check($sformatf("u%0d_press", u),   32'(op),  32'(ep));
      check($sformatf("u%0d_release", u), 32'(orl), 32'(er));
      check($sformatf("u%0d_toggle", u),  32'(ot),  32'(et));
      check($sformatf("u%0d_state", u),   32'(os),  32'(es));
      check($sformatf("u%0d_any", u),     32'(oa),  32'(|{ep, er}));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  // Runs maxc cycles; fp is the 1-based cycle of the first press pulse on the channel.
  task automatic measure(input int u, input int ch, input int maxc,
                         output int fp, output int np, output int nr);
    logic p, r;
    fp = 0; np = 0; nr = 0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      p = (u == 0) ? prs0[ch] : prs1[ch];
      r = (u == 0) ? rel0[ch] : rel1[ch];
      if (p) begin
        np++;
        if (fp == 0) fp = i;
      end
      if (r) nr++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fp, np, nr, nev, pcnt;
    logic [NSW-1:0] pval;
    logic pany;
    int hold [2][NSW];

    model_reset();
    isReset = 1'b1;
    sw0 = '0;
    sw1 = '1;
    repeat (3) @(negedge clock);
    isReset = 1'b0;
    compare_all();
    check("rst_level", 32'(lvl0), 32'h0);
    check("rst_toggle", 32'(tog0), 32'h0);
    check("rst_al_level", 32'(lvl1), 32'h0);

    // Idle inputs (including the active-low instance held high) give no events.
    nev = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (any0 || any1) nev++;
    end
    check("idle_events", 32'(nev), 32'h0);
    sw1 = 4'b1110;
    measure(1, 0, 30, fp, np, nr);
    check("al_press_lat", 32'(fp), 32'd18);
    sw1 = '1;
    repeat (30) tick();

    // Clean press / release / second press on ch0.
    sw0 = 4'b0001;
    measure(0, 0, 40, fp, np, nr);
    check("a_press_lat", 32'(fp), 32'd18);
    check("a_press_cnt", 32'(np), 32'd1);
    check("a_toggle1", 32'(tog0[0]), 32'd1);
    sw0 = 4'b0000;
    measure(0, 0, 40, fp, np, nr);
    check("a_release_cnt", 32'(nr), 32'd1);
    check("a_toggle_hold", 32'(tog0[0]), 32'd1);
    sw0 = 4'b0001;
    measure(0, 0, 40, fp, np, nr);
    check("a_toggle0", 32'(tog0[0]), 32'd0);
    sw0 = 4'b0000;
    repeat (40) tick();

    // ch1: high 10, low 3, high 30 -> one press 18 edges after the last rise.
    fp = 0; np = 0;
    for (int i = 1; i <= 73; i++) begin
      sw0[1] = (i <= 10) || (i >= 14 && i <= 43);
      tick();
      if (prs0[1]) begin
        np++;
        if (fp == 0) fp = i;
      end
    end
    check("b_bounce_lat", 32'(fp), 32'd31);
    check("b_bounce_cnt", 32'(np), 32'd1);

    np = 0;
    for (int i = 1; i <= 45; i++) begin
      sw0[1] = (i <= 15);
      tick();
      if (any0) np++;
    end
    check("b_glitch15", 32'(np), 32'd0);
    fp = 0; np = 0;
    for (int i = 1; i <= 45; i++) begin
      sw0[1] = (i <= 16);
      tick();
      if (prs0[1]) begin
        np++;
        if (fp == 0) fp = i;
      end
    end
    check("b_pulse16_cnt", 32'(np), 32'd1);
    check("b_pulse16_lat", 32'(fp), 32'd18);

    // Simultaneous press on ch2 and ch3.
    sw0 = 4'b1100;
    pcnt = 0; pval = '0; pany = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (prs0 != '0) begin
        pcnt++;
        pval = prs0;
        pany = any0;
      end
    end
    check("c_press_cycles", 32'(pcnt), 32'd1);
    check("c_press_bits", 32'(pval), 32'hc);
    check("c_any", 32'(pany), 32'd1);
    sw0 = 4'b0000;
    repeat (30) tick();

    // Reset while the ch0 count is 10 restarts the whole latency.
    sw0 = 4'b0001;
    repeat (12) tick();
    check("d_counting", 32'(st0[0]), 32'd1);
    isReset = 1'b1;
    model_reset();
    tick();
    isReset = 1'b0;
    measure(0, 0, 30, fp, np, nr);
    check("d_restart_lat", 32'(fp), 32'd18);
    check("d_pre_toggle", 32'(tog0[0]), 32'd1);

    // Asynchronous clear between edges.
    #2 isReset = 1'b1;
    model_reset();
    #1;
    check("e_async_level", 32'(lvl0), 32'h0);
    check("e_async_toggle", 32'(tog0), 32'h0);
    check("e_async_any", 32'(any0), 32'h0);
    compare_all();
    sw0 = 4'b0000;
    @(negedge clock);
    isReset = 1'b0;

    // Randomised holds: short glitches, lengths around the threshold, and long holds.
    for (int u = 0; u < 2; u++)
      for (int ch = 0; ch < NSW; ch++) hold[u][ch] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        for (int ch = 0; ch < NSW; ch++) begin
          if (hold[u][ch] == 0) begin
            if (u == 0) sw0[ch] = ~sw0[ch];
            else        sw1[ch] = ~sw1[ch];
            case ($urandom_range(0, 2))
              0:       hold[u][ch] = $urandom_range(1, 4);
              1:       hold[u][ch] = $urandom_range(DEB - 2, DEB + 1);
              default: hold[u][ch] = $urandom_range(DEB + 2, 40);
            endcase
          end else begin
            hold[u][ch]--;
          end
        end
      end
      tick();
      if (cyc == 750) begin
        #2 isReset = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clock);
        isReset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter NUM_SWITCHES, default 4, number of independent switch channels (>=1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronised samples required to accept a change (>=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; when 1, a raw input low means pressed.
REQ-005 SHALL have port clock  input  1  single rising-edge clock for all logic.
REQ-006 SHALL have port isReset  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port switchIn  input  NUM_SWITCHES  raw, asynchronous, bouncing switch inputs.
REQ-008 SHALL have port switchLevel  output  NUM_SWITCHES  debounced level, 1 = pressed.
REQ-009 SHALL have port switchPress  output  NUM_SWITCHES  one-cycle pulse on accepted press.
REQ-010 SHALL have port switchRelease  output  NUM_SWITCHES  one-cycle pulse on accepted release.
REQ-011 SHALL have port switchToggle  output  NUM_SWITCHES  state flipping on every accepted press.
REQ-012 SHALL have port anyEvent  output  1  OR of all switchPress and switchRelease bits.

Function
REQ-013 Each channel SHALL pass switchIn through SYNC_STAGES flops, then invert when ACTIVE_LOW=1, giving a synchronised sample where 1 = pressed.
REQ-014 Each channel SHALL run a two-state FSM: STABLE (sample == switchLevel, counter 0) and COUNTING (sample != switchLevel).
REQ-015 STABLE -> COUNTING when the sample differs from switchLevel; the counter becomes 1 at that edge.
REQ-016 In COUNTING, the counter SHALL increment each edge while the sample still differs; if the sample equals switchLevel, the counter clears and the FSM returns to STABLE with no output change.
REQ-017 At the edge where the counter equals DEBOUNCE_CYCLES-1 and the sample still differs, switchLevel SHALL invert, the counter clears, and the FSM returns to STABLE.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-019 Latency: for a clean change of switchIn set up before edge 1, switchLevel SHALL change after edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 18).
REQ-020 A synchronised pulse or glitch of DEBOUNCE_CYCLES-1 cycles or fewer SHALL produce no level change and no event.
REQ-021 switchPress/switchRelease SHALL be registered and asserted for exactly the one cycle in which switchLevel has just risen/fallen.
REQ-022 switchToggle SHALL flip in the same cycle switchPress is asserted and SHALL be unaffected by releases.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-024 anyEvent SHALL be combinational from the registered pulse outputs, with no added latency.

Reset
REQ-025 isReset high SHALL immediately, without a clock edge, clear switchLevel, switchPress, switchRelease, switchToggle, anyEvent, all counters and FSMs (to STABLE).
REQ-026 Synchroniser flops SHALL reset to the inactive raw level (0 when ACTIVE_LOW=0, 1 when ACTIVE_LOW=1), so an idle input gives no event after reset.
REQ-027 Reset mid-count SHALL abandon the count; after release, a full SYNC_STAGES+DEBOUNCE_CYCLES is required again.
REQ-028 Deassertion SHALL be sampled on the next rising edge; the first FSM update SHALL occur on the first edge with isReset low.

Verification (defaults unless noted)
REQ-029 Assert isReset between edges with switchLevel[0]=1, switchToggle[0]=1 -> all outputs 0 before the next edge.
REQ-030 Clean press on ch0 held 40 cycles -> switchLevel[0] rises after edge 18, switchPress[0] and anyEvent high exactly 1 cycle, switchToggle[0]=1; release -> switchRelease[0] 1 cycle, toggle stays 1; second press -> toggle 0.
REQ-031 ch1 high 10 cycles, low 3, high 30 -> exactly one switchPress[1], 18 edges after the last rising transition; ch1 high 15 cycles only -> no event; high 16 cycles -> event.
REQ-032 ch2 and ch3 pressed on the same edge -> both switchPress bits and anyEvent high in the same single cycle; ch0/ch1 unaffected.
REQ-033 Reset pulse while the ch0 counter is 10, input held high -> after release, switchLevel[0] rises only 18 edges after reset deassertion.
REQ-034 ACTIVE_LOW=1 instance, all inputs held 1 through and after reset -> no events for 100 cycles; drive ch0 low -> press after edge 18.
